spi_word_tx: RTL and testbench
==============================

# spi_word_tx

Parametrised SPI transmit serializer: accepts a DATA_W-bit word over a valid/ready handshake, then shifts it out on mosi with a generated sclk and an active-high frame enable. It sits between the hash-table output stage and the board-level SPI pins. It succeeds the fixed 8-bit sender with configurable width, bit order, clock division, inter-frame gap and a completion pulse.

## Interface
Parameters:
- DATA_W, 8, word width in bits, ≥ 2
- CLK_DIV, 2, clk cycles per sclk half-period, ≥ 1
- MSB_FIRST, 0, 1 = transmit bit DATA_W-1 first; 0 = transmit bit 0 first
- GAP_CYC, 2, idle cycles with en low between frames, ≥ 1

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- in_data  in  DATA_W  word to send
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept a word
- sclk  out  1  SPI clock, idle low
- mosi  out  1  serial data
- en  out  1  frame enable, high for the whole frame
- done  out  1  one-cycle pulse when a frame completes

## Operation
- FSM states: IDLE, SHIFT, GAP.
- IDLE: in_ready=1, en=0, sclk=0, mosi=0. On in_valid && in_ready, latch in_data into the shift register, clear the bit counter, go to SHIFT.
- SHIFT: en=1. mosi holds the current bit for 2*CLK_DIV cycles. sclk is 0 for the first CLK_DIV cycles of each bit and 1 for the next CLK_DIV cycles (SPI mode 0: mosi changes while sclk is low, is sampled on the rising edge).
- After the high phase of the last bit, go to GAP.
- GAP: en=0, sclk=0, mosi=0, in_ready=0 for GAP_CYC cycles. done=1 on the first GAP cycle only. Then go to IDLE.
- Bit order: MSB_FIRST=0 shifts right and drives sr[0]. MSB_FIRST=1 shifts left and drives sr[DATA_W-1].
- in_data is captured only at the handshake; changes during SHIFT or GAP have no effect.
- in_ready is 0 in SHIFT and GAP. A valid presented there is held off, not dropped.
- Counter widths: bit counter $clog2(DATA_W+1), divider counter $clog2(CLK_DIV+1). Neither counter wraps mid-frame.

## Timing
- Reset values: in_ready=0 while rst is high, sclk=0, mosi=0, en=0, done=0. State is IDLE, so in_ready=1 on the first cycle after rst falls.
- Handshake at cycle T: en=1 and mosi=first bit at T+1; first sclk rise at T+1+CLK_DIV.
- Frame length: en high for DATA_W*2*CLK_DIV cycles (plus 2*CLK_DIV when parity is enabled).
- done at the cycle after en falls. in_ready returns GAP_CYC cycles after en falls.
- Back-to-back frames: minimum spacing between en rising edges = frame length + GAP_CYC + 1.
- rst mid-frame takes effect the next cycle: all outputs reset, frame discarded, no done pulse.
- rst and in_valid in the same cycle: rst wins, word not accepted.

## Configuration
- SPI_WORD_TX_PARITY_EN defined: one extra bit follows the data bits, with the same 2*CLK_DIV timing. It is the even-parity bit, the XOR of the latched word.
- Not defined: frames are exactly DATA_W bits and no parity logic is present.

## Structure
- Shared package spi_pkg holds:
  - the state encoding constants (IDLE/SHIFT/GAP)
  - parameter legality checks (DATA_W ≥ 2, CLK_DIV ≥ 1, GAP_CYC ≥ 1)
  - a frame-length function used by this block and the matching receiver
- Sub-module spi_bit_timer: a CLK_DIV divider that outputs sclk_rise and bit_end strobes. It is enabled only in SHIFT and cleared on the handshake and on rst.

## Test plan
All scenarios use DATA_W=8, CLK_DIV=2, GAP_CYC=2 unless noted.
- MSB_FIRST=0, send 0xA5:
  - mosi = 1,0,1,0,0,1,0,1, each held 4 cycles
  - sclk rises 2 cycles into each bit
  - en high 32 cycles; done one pulse the cycle after en falls
- MSB_FIRST=1, send 0x80: mosi = 1 then seven 0s; en high 32 cycles.
- in_valid held with 0x01 then 0xFF:
  - in_ready low from handshake until 2 cycles after done
  - second en rise 35 cycles after the first
  - in_data changed mid-frame does not alter mosi
- rst pulsed at cycle 10 of a frame: en, sclk, mosi = 0 the next cycle; no done; in_ready=1 the cycle after rst falls.
- CLK_DIV=1, DATA_W=4, send 0xC: mosi 0,0,1,1 each held 2 cycles; sclk toggles every cycle; en high 8 cycles.
- SPI_WORD_TX_PARITY_EN defined, send 0x07: 9th bit = 1; en high 36 cycles.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI state encoding, parameter checks and frame-length helper.
package spi_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
   function automatic bit params_ok(input int data_w, input int clk_div, input int gap_cyc);
      return data_w >= 2 && clk_div >= 1 && gap_cyc >= 1;
   endfunction
   function automatic int frame_bits(input int data_w, input int parity_en);
      return data_w + (parity_en != 0 ? 1 : 0);
   endfunction
endpackage

// File: rtl/spi_word_tx_if.sv
// spi_word_tx_if: valid/ready word handshake into the SPI serializer.
interface spi_word_tx_if #(parameter int DATA_W = 8) ();
   logic [DATA_W-1:0] in_data;
   logic in_valid;
   logic in_ready;
   modport master (output in_data, output in_valid, input in_ready);
   modport slave (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/spi_bit_timer.sv
// spi_bit_timer: CLK_DIV half-period divider producing sclk_rise and bit_end strobes.
module spi_bit_timer #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic run,
   output logic sclk_rise,
   output logic bit_end
);
   localparam int CW = $clog2(CLK_DIV + 1);
   logic [CW-1:0] cnt;
   logic hi, wrap;
   assign wrap = run && cnt == CW'(CLK_DIV - 1);
   assign sclk_rise = wrap && !hi;
   assign bit_end = wrap && hi;
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
         hi <= 1'b0;
      end else if (run) begin
         cnt <= wrap ? '0 : cnt + 1'b1;
         hi <= hi ^ wrap;
      end
   end
endmodule

// File: rtl/spi_word_tx.sv
// spi_word_tx: SPI mode-0 word serializer with valid/ready input and done pulse.
// Optional trailing even-parity bit when SPI_WORD_TX_PARITY_EN is defined.
module spi_word_tx
   import spi_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CLK_DIV = 2,
   parameter int MSB_FIRST = 0,
   parameter int GAP_CYC = 2
) (
   input  logic clk,
   input  logic rst,
   spi_word_tx_if.slave s,
   output logic sclk,
   output logic mosi,
   output logic en,
   output logic done
);
`ifdef SPI_WORD_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int BW = $clog2(DATA_W + 1);
   localparam int GW = $clog2(GAP_CYC + 1);
   localparam int NB = frame_bits(DATA_W, PAR);
   if (!params_ok(DATA_W, CLK_DIV, GAP_CYC)) begin : g_bad_params
      $error("spi_word_tx: illegal parameters");
   end
   state_t state, state_n;
   logic [DATA_W-1:0] sr;
   logic [BW-1:0] bcnt;
   logic [GW-1:0] gcnt;
   logic acc, sclk_rise, bit_end, last, gap_end, data_bit, bit_val;
   // in_ready is forced low during rst so a same-cycle valid is never accepted
   assign s.in_ready = state == IDLE && !rst;
   assign acc = s.in_valid && s.in_ready;
   assign last = bcnt == BW'(NB - 1);
   assign gap_end = gcnt == GW'(GAP_CYC - 1);
   assign data_bit = MSB_FIRST != 0 ? sr[DATA_W-1] : sr[0];
   spi_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
      .clk(clk),
      .rst(rst),
      .clr(acc),
      .run(state == SHIFT),
      .sclk_rise(sclk_rise),
      .bit_end(bit_end)
   );
`ifdef SPI_WORD_TX_PARITY_EN
   logic par;
   always_ff @(posedge clk) par <= rst ? 1'b0 : acc ? ^s.in_data : par;
   assign bit_val = bcnt == BW'(DATA_W) ? par : data_bit;
`else
   assign bit_val = data_bit;
`endif
   always_ff @(posedge clk) state <= rst ? IDLE : state_n;
   always_comb begin
      state_n = state == IDLE ? (acc ? SHIFT : IDLE)
              : state == SHIFT ? (bit_end && last ? GAP : SHIFT)
              : (gap_end ? IDLE : GAP);
      en = state == SHIFT;
      mosi = state == SHIFT && bit_val;
      done = state == GAP && gcnt == '0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         sr <= '0;
         bcnt <= '0;
      end else if (acc) begin
         sr <= s.in_data;
         bcnt <= '0;
      end else if (bit_end && !last) begin
         sr <= MSB_FIRST != 0 ? sr << 1 : sr >> 1;
         bcnt <= bcnt + 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      gcnt <= !rst && state == GAP ? gcnt + 1'b1 : '0;
      sclk <= rst || acc ? 1'b0 : sclk_rise ? 1'b1 : bit_end ? 1'b0 : sclk;
   end
endmodule

// File: tb/tb_spi_word_tx.sv
// tb_spi_word_tx: three serializer configurations checked cycle by cycle against a waveform model.
module tb_spi_word_tx;
`ifdef SPI_WORD_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic valid = 1'b0;
   logic [7:0] data = 8'h00;
   logic [1:0] sel = 2'd0;
   int n = 0;
   int fails = 0;
   int cyc = 0;
   int last_rise = 0;
   logic [2:0] sclk_v, mosi_v, en_v, done_v;
   logic o_ready, o_sclk, o_mosi, o_en, o_done;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   spi_word_tx_if #(.DATA_W(8)) if0 ();
   spi_word_tx_if #(.DATA_W(8)) if1 ();
   spi_word_tx_if #(.DATA_W(4)) if2 ();
   assign if0.in_valid = valid && sel == 2'd0;
   assign if1.in_valid = valid && sel == 2'd1;
   assign if2.in_valid = valid && sel == 2'd2;
   assign if0.in_data = data;
   assign if1.in_data = data;
   assign if2.in_data = data[3:0];
   spi_word_tx #(.DATA_W(8), .CLK_DIV(2), .MSB_FIRST(0), .GAP_CYC(2)) d0 (
      .clk(clk), .rst(rst), .s(if0), .sclk(sclk_v[0]), .mosi(mosi_v[0]), .en(en_v[0]), .done(done_v[0]));
   spi_word_tx #(.DATA_W(8), .CLK_DIV(2), .MSB_FIRST(1), .GAP_CYC(2)) d1 (
      .clk(clk), .rst(rst), .s(if1), .sclk(sclk_v[1]), .mosi(mosi_v[1]), .en(en_v[1]), .done(done_v[1]));
   spi_word_tx #(.DATA_W(4), .CLK_DIV(1), .MSB_FIRST(0), .GAP_CYC(2)) d2 (
      .clk(clk), .rst(rst), .s(if2), .sclk(sclk_v[2]), .mosi(mosi_v[2]), .en(en_v[2]), .done(done_v[2]));
   always_comb begin
      o_ready = sel == 2'd0 ? if0.in_ready : sel == 2'd1 ? if1.in_ready : if2.in_ready;
      o_sclk = sclk_v[sel];
      o_mosi = mosi_v[sel];
      o_en = en_v[sel];
      o_done = done_v[sel];
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   // bit b of the transmitted frame: data bits in the configured order, then parity
   function automatic logic exp_bit(input logic [7:0] w, input int dw, input int msb, input int b);
      logic [7:0] m;
      m = w & 8'((1 << dw) - 1);
      if (b == dw) return ^m;
      return msb != 0 ? m[dw-1-b] : m[b];
   endfunction
   task automatic frame(input logic [7:0] w, input int dw, input int cd, input int msb, input int gap,
                        input bit hold, input logic [7:0] nxt, input bit spc);
      int f;
      f = (dw + PAR) * 2 * cd;
      for (int k = 0; k < f; k++) begin
         @(negedge clk);
         if (k == 0) begin
            if (spc) chk("en_rise_spacing", cyc - last_rise, f + gap + 1);
            last_rise = cyc;
            if (hold) data = nxt;
            else valid = 1'b0;
         end
         if (!hold) data = 8'($urandom);
         chk("frame_en", o_en, 1);
         chk("frame_sclk", o_sclk, (k % (2 * cd)) >= cd);
         chk("frame_mosi", o_mosi, exp_bit(w, dw, msb, k / (2 * cd)));
         chk("frame_ready", o_ready, 0);
         chk("frame_done", o_done, 0);
      end
      for (int g = 0; g < gap; g++) begin
         @(negedge clk);
         chk("gap_en", o_en, 0);
         chk("gap_sclk", o_sclk, 0);
         chk("gap_mosi", o_mosi, 0);
         chk("gap_ready", o_ready, 0);
         chk("gap_done", o_done, g == 0);
      end
      @(negedge clk);
      chk("ready_back", o_ready, 1);
      chk("idle_en", o_en, 0);
   endtask
   initial begin
      logic [7:0] w;
      repeat (3) @(negedge clk);
      chk("rst_ready", o_ready, 0);
      chk("rst_en", o_en, 0);
      chk("rst_sclk", o_sclk, 0);
      chk("rst_mosi", o_mosi, 0);
      chk("rst_done", o_done, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", o_ready, 1);
      sel = 2'd0; data = 8'hA5; valid = 1'b1;
      frame(8'hA5, 8, 2, 0, 2, 1'b0, 8'h00, 1'b0);
      sel = 2'd1; data = 8'h80; valid = 1'b1;
      frame(8'h80, 8, 2, 1, 2, 1'b0, 8'h00, 1'b0);
      sel = 2'd2; data = 8'h0C; valid = 1'b1;
      frame(8'h0C, 4, 1, 0, 2, 1'b0, 8'h00, 1'b0);
      sel = 2'd0; data = 8'h07; valid = 1'b1;
      frame(8'h07, 8, 2, 0, 2, 1'b0, 8'h00, 1'b0);
      sel = 2'd0; data = 8'h01; valid = 1'b1;
      frame(8'h01, 8, 2, 0, 2, 1'b1, 8'hFF, 1'b0);
      frame(8'hFF, 8, 2, 0, 2, 1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 4; i++) begin
         for (int s = 0; s < 3; s++) begin
            w = 8'($urandom);
            sel = 2'(s); data = w; valid = 1'b1;
            frame(w, s == 2 ? 4 : 8, s == 2 ? 1 : 2, s == 1 ? 1 : 0, 2, 1'b0, 8'h00, 1'b0);
         end
      end
      // reset ten cycles into a frame discards it without a done pulse
      sel = 2'd0; data = 8'($urandom); valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (k == 0) valid = 1'b0;
         chk("pre_rst_en", o_en, 1);
      end
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_en", o_en, 0);
      chk("midrst_sclk", o_sclk, 0);
      chk("midrst_mosi", o_mosi, 0);
      chk("midrst_ready", o_ready, 0);
      chk("midrst_done", o_done, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_ready_back", o_ready, 1);
      chk("midrst_no_done", o_done, 0);
      repeat (3) begin
         @(negedge clk);
         chk("after_rst_done", o_done, 0);
         chk("after_rst_en", o_en, 0);
      end
      data = 8'($urandom); valid = 1'b1; rst = 1'b1;
      @(negedge clk);
      chk("rst_valid_en", o_en, 0);
      chk("rst_valid_ready", o_ready, 0);
      rst = 1'b0; valid = 1'b0;
      @(negedge clk);
      chk("rst_valid_en2", o_en, 0);
      chk("rst_valid_ready2", o_ready, 1);
      @(negedge clk);
      chk("rst_valid_en3", o_en, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
      $finish;
   end
endmodule
